// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore sequencing FSM, ALU decoder and retired-instruction counter.
// Write enables are gated by rst_n so that nothing writes while reset is held.
module multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           imm_src,
   output logic [2:0]           alu_sel,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instret_cnt
);

   // state    | meaning
   // FETCH    | read instruction at PC into IR, PC <= PC + 4
   // DECODE   | read registers, branch target into ALUOut, dispatch on opcode
   // MEMADR   | compute load/store address
   // MEMREAD  | read data memory at ALUOut
   // MEMWB    | write loaded data to register file
   // MEMWRITE | write B to data memory at ALUOut
   // EXECR    | R-type ALU operation
   // EXECI    | I-type ALU operation
   // ALUWB    | write ALUOut to register file
   // JAL      | PC <= target, OldPC + 4 into ALUOut
   // BEQ      | compare A and B, take branch when equal

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   state_t state, state_nxt;
   logic   pc_update, branch;
   logic   mem_write_int, ir_write_int, reg_write_int;
   logic   funct3_bad;
   logic [2:0] funct_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         instret_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BEQ)
            instret_cnt <= instret_cnt + CNT_WIDTH'(1);
      end
   end

   assign funct3_bad = (funct3 == 3'b001) || (funct3 == 3'b011) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);

   // funct7b5 selects SUB only for R-type ADD; I-type has no SUBI
   always_comb begin
      funct_op = ALU_ADD;
      case (funct3)
         3'b000:  funct_op = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_op = ALU_SLT;
         3'b110:  funct_op = ALU_OR;
         3'b111:  funct_op = ALU_AND;
         default: funct_op = ALU_ADD;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      pc_update     = 1'b0;
      branch        = 1'b0;
      adr_src       = 1'b0;
      mem_write_int = 1'b0;
      ir_write_int  = 1'b0;
      reg_write_int = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_sel       = ALU_ADD;
      illegal       = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write_int = 1'b1;
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
            pc_update    = 1'b1;
            state_nxt    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_R:         state_nxt = funct3_bad ? S_FETCH : S_EXECR;
               OP_I:         state_nxt = funct3_bad ? S_FETCH : S_EXECI;
               OP_JAL:       state_nxt = S_JAL;
               OP_BEQ:       state_nxt = S_BEQ;
               default:      state_nxt = S_FETCH;
            endcase
            if (state_nxt == S_FETCH)
               illegal = 1'b1;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src   = 1'b1;
            state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_int = 1'b1;
            state_nxt     = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            mem_write_int = 1'b1;
            state_nxt     = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_sel   = funct_op;
            state_nxt = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_sel   = funct_op;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_int = 1'b1;
            state_nxt     = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_sel   = ALU_SUB;
            branch    = 1'b1;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   assign pc_write  = rst_n & (pc_update | (branch & zero));
   assign ir_write  = rst_n & ir_write_int;
   assign reg_write = rst_n & reg_write_int;
   assign mem_write = rst_n & mem_write_int;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its expected per-cycle
// control words, which are popped and compared once per cycle on the falling edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_sel;
   logic [3:0] instret_cnt;

   multicycle_ctrl #(.CNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_sel(alu_sel),
      .illegal(illegal), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

   typedef struct packed {
      logic [16:0] ctrl;
      logic [3:0]  cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_cnt = 4'd0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ill);
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
   endfunction

   function automatic logic [16:0] obs_word();
      return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, alu_sel, illegal};
   endfunction

   task automatic reset_checks(input string tag);
      check_eq({tag, " ctrl"}, 32'(obs_word()),
               32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd2, 1'b0)));
      check_eq({tag, " cnt"}, 32'(instret_cnt), 32'd0);
   endtask

   task automatic run(input string name, input int kind, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic [2:0] alu);
      logic [1:0] imm;
      exp_t       e;
      int         step;
      case (op)
         7'b0100011: imm = 2'b01;
         7'b1100011: imm = 2'b10;
         7'b1101111: imm = 2'b11;
         default:    imm = 2'b00;
      endcase
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
      e.cnt = exp_cnt;
      e.ctrl = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'd2, 0);
      sb_q.push_back(e);
      e.ctrl = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'd2, kind == K_ILL);
      sb_q.push_back(e);
      case (kind)
         K_LW: begin
            e.ctrl = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'd2, 0); sb_q.push_back(e);
            e.ctrl = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
            e.ctrl = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
         end
         K_SW: begin
            e.ctrl = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'd2, 0); sb_q.push_back(e);
            e.ctrl = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
         end
         K_R: begin
            e.ctrl = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, alu, 0);  sb_q.push_back(e);
            e.ctrl = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
         end
         K_I: begin
            e.ctrl = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, alu, 0);  sb_q.push_back(e);
            e.ctrl = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
         end
         K_JAL: begin
            e.ctrl = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'd2, 0); sb_q.push_back(e);
            e.ctrl = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'd2, 0); sb_q.push_back(e);
         end
         K_BEQ: begin
            e.ctrl = mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'd6, 0); sb_q.push_back(e);
         end
         default: ;
      endcase
      step = 0;
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         check_eq($sformatf("%s c%0d ctrl", name, step), 32'(obs_word()), 32'(e.ctrl));
         check_eq($sformatf("%s c%0d cnt", name, step), 32'(instret_cnt), 32'(e.cnt));
         check_eq($sformatf("%s c%0d alu_legal", name, step),
                  32'(alu_sel inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7}), 32'd1);
         @(posedge clk);
         #1;
         step++;
      end
      if (kind != K_ILL) exp_cnt = exp_cnt + 4'd1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      reset_checks("por");
      @(posedge clk);
      #1 rst_n = 1'b1;

      run("lw", K_LW, 7'b0000011, 3'b010, 1'b0, 1'b0, 3'd2);
      run("sw", K_SW, 7'b0100011, 3'b010, 1'b0, 1'b1, 3'd2);
      run("sub", K_R, 7'b0110011, 3'b000, 1'b1, 1'b0, 3'd6);
      run("add", K_R, 7'b0110011, 3'b000, 1'b0, 1'b0, 3'd2);
      run("slt", K_R, 7'b0110011, 3'b010, 1'b1, 1'b0, 3'd7);
      run("or", K_R, 7'b0110011, 3'b110, 1'b0, 1'b0, 3'd1);
      run("and", K_R, 7'b0110011, 3'b111, 1'b1, 1'b0, 3'd0);
      run("addi_f7", K_I, 7'b0010011, 3'b000, 1'b1, 1'b0, 3'd2);
      run("slti", K_I, 7'b0010011, 3'b010, 1'b0, 1'b0, 3'd7);
      run("andi", K_I, 7'b0010011, 3'b111, 1'b0, 1'b0, 3'd0);
      run("jal", K_JAL, 7'b1101111, 3'b000, 1'b0, 1'b1, 3'd2);
      run("beq_t", K_BEQ, 7'b1100011, 3'b000, 1'b0, 1'b1, 3'd6);
      run("beq_nt", K_BEQ, 7'b1100011, 3'b000, 1'b0, 1'b0, 3'd6);
      run("ill_lui", K_ILL, 7'b0110111, 3'b000, 1'b0, 1'b0, 3'd2);
      run("ill_r001", K_ILL, 7'b0110011, 3'b001, 1'b0, 1'b0, 3'd2);
      run("ill_i101", K_ILL, 7'b0010011, 3'b101, 1'b0, 1'b0, 3'd2);

      // abort an R-type in EXECR with an asynchronous reset
      opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("execr pre_rst alu", 32'(alu_sel), 32'd6);
      check_eq("execr pre_rst cnt", 32'(instret_cnt), 32'(exp_cnt));
      #2 rst_n = 1'b0;
      #1 reset_checks("mid_rst");
      @(posedge clk); #1;
      reset_checks("mid_rst held");
      rst_n = 1'b1;
      exp_cnt = 4'd0;

      for (int i = 0; i < 18; i++)
         run($sformatf("addi%0d", i), K_I, 7'b0010011, 3'b000, 1'b0, 1'b0, 3'd2);
      @(negedge clk);
      check_eq("final cnt", 32'(instret_cnt), 32'(exp_cnt));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
